mtmr: RTL

MTMR -- requirements
Module: mtmr

---
 rtl/mtmr.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/mtmr.sv
// ---------------------------------------------------------------------------
// mtmr -- multi-channel programmable interval timer
//
// Each channel has a CTRL register (EXP, IEN, ONESHOT, RUN), a CW-bit DIVISOR
// and a read-only CW-bit down-counter. A running channel decrements its
// counter on every tick. When the counter reaches 1 on a tick, the channel
// expires. It then either reloads from DIVISOR (periodic) or stops at 0
// (one-shot). The channel interrupt is EXP AND IEN.
//
// Optional feature: define MTMR_PRESCALER_EN to add a shared 16-bit PRESCALE
// register at channel 0 register 3. It produces one tick every PRESCALE+1
// clocks. Without the macro the tick fires on every clock.
//
// Register map: addr[7:4] = channel, addr[3:2] = register
//   0 CTRL     {28'b0, RUN, ONESHOT, IEN, EXP}
//   1 DIVISOR  R/W, zero-extended
//   2 COUNTER  read-only, zero-extended
//   3 (ch0 only, with MTMR_PRESCALER_EN) PRESCALE, otherwise reads 0
//
// Ports:
//   clk       system clock (single domain)
//   reset     synchronous active-high reset
//   en        bus access strobe
//   wr        1 = write, 0 = read
//   addr      word address [7:2]
//   data_in   write data
//   data_out  combinational read data (0 when idle, unmapped or in reset)
//   wt        bus wait, always 0
//   irq       per-channel interrupt request
// ---------------------------------------------------------------------------
module mtmr #(
  parameter int NCHAN = 4,
  parameter int CW    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             wr,
  input  logic [7:2]       addr,
  input  logic [31:0]      data_in,
  output logic [31:0]      data_out,
  output logic             wt,
  output logic [NCHAN-1:0] irq
);

  logic [3:0]  w_ch;
  logic [1:0]  w_rsel;
  logic        w_bus_wr;
  logic        w_tick;
  logic [31:0] w_pre_rd;
  logic [31:0] w_pre_sel;

  // OR-chain that merges per-channel read data; only the addressed channel
  // contributes a non-zero word.
  logic [NCHAN:0][31:0] w_rd_chain;

  assign w_ch     = addr[7:4];
  assign w_rsel   = addr[3:2];
  assign w_bus_wr = en & wr;
  assign wt       = 1'b0;

  // -------------------------------------------------------------------------
  // Tick generation
  // -------------------------------------------------------------------------
`ifdef MTMR_PRESCALER_EN
  logic [15:0] r_prescale;
  logic [15:0] r_pcnt;
  logic        w_pre_wr;

  assign w_pre_wr = w_bus_wr && (w_ch == 4'd0) && (w_rsel == 2'd3);
  assign w_tick   = (r_pcnt == r_prescale);
  assign w_pre_rd = {16'h0000, r_prescale};

  // Writing PRESCALE restarts the shared divider so the first tick after a
  // reprogram comes a full PRESCALE+1 clocks later.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_prescale <= 16'h0000;
      r_pcnt     <= 16'h0000;
    end else if (w_pre_wr) begin
      r_prescale <= data_in[15:0];
      r_pcnt     <= 16'h0000;
    end else if (w_tick) begin
      r_pcnt     <= 16'h0000;
    end else begin
      r_pcnt     <= r_pcnt + 16'd1;
    end
  end
`else
  assign w_tick   = 1'b1;
  assign w_pre_rd = 32'h0000_0000;
`endif

  // -------------------------------------------------------------------------
  // Timer channels
  // -------------------------------------------------------------------------
  assign w_rd_chain[0] = 32'h0000_0000;

  generate
    for (genvar gi = 0; gi < NCHAN; gi++) begin : g_chan
      logic          r_exp;
      logic          r_ien;
      logic          r_oneshot;
      logic          r_run;
      logic [CW-1:0] r_div;
      logic [CW-1:0] r_cnt;

      logic          w_sel;
      logic          w_wr_ctrl;
      logic          w_wr_div;
      logic          w_adv;
      logic          w_expire;
      logic [31:0]   w_ctrl32;
      logic [31:0]   w_div32;
      logic [31:0]   w_cnt32;
      logic [31:0]   w_rd;

      assign w_sel     = (w_ch == 4'(gi));
      assign w_wr_ctrl = w_bus_wr && w_sel && (w_rsel == 2'd0);
      assign w_wr_div  = w_bus_wr && w_sel && (w_rsel == 2'd1);

      // A counter at 0 is parked: it never expires, so DIVISOR=0 is inert.
      assign w_adv    = w_tick && r_run && (r_cnt != '0);
      assign w_expire = w_adv && (r_cnt == CW'(1));

      always_ff @(posedge clk) begin
        if (reset) begin
          r_exp     <= 1'b0;
          r_ien     <= 1'b0;
          r_oneshot <= 1'b0;
          r_run     <= 1'b0;
          r_div     <= '0;
          r_cnt     <= '0;
        end else begin
          if (w_wr_div) begin
            r_div <= data_in[CW-1:0];
          end

          // A DIVISOR write overrides the reload or decrement that an
          // expiry would otherwise perform. EXP is still set below.
          if (w_wr_div) begin
            r_cnt <= data_in[CW-1:0];
          end else if (w_adv) begin
            if (r_cnt == CW'(1)) begin
              r_cnt <= r_oneshot ? '0 : r_div;
            end else begin
              r_cnt <= r_cnt - CW'(1);
            end
          end

          // Expiry beats a simultaneous clear so no event is lost.
          if (w_expire) begin
            r_exp <= 1'b1;
          end else if (w_wr_ctrl && !data_in[0]) begin
            r_exp <= 1'b0;
          end

          // A CTRL write beats the one-shot auto-stop, so software can
          // re-arm on the expiry edge.
          if (w_wr_ctrl) begin
            r_ien     <= data_in[1];
            r_oneshot <= data_in[2];
            r_run     <= data_in[3];
          end else if (w_expire && r_oneshot) begin
            r_run     <= 1'b0;
          end
        end
      end

      assign irq[gi] = !reset && r_exp && r_ien;

      assign w_ctrl32 = {28'h000_0000, r_run, r_oneshot, r_ien, r_exp};

      if (CW < 32) begin : g_zext
        assign w_div32 = {{(32-CW){1'b0}}, r_div};
        assign w_cnt32 = {{(32-CW){1'b0}}, r_cnt};
      end else begin : g_full
        assign w_div32 = r_div;
        assign w_cnt32 = r_cnt;
      end

      always_comb begin
        w_rd = 32'h0000_0000;
        case (w_rsel)
          2'd0:    w_rd = w_ctrl32;
          2'd1:    w_rd = w_div32;
          2'd2:    w_rd = w_cnt32;
          default: w_rd = 32'h0000_0000;
        endcase
      end

      assign w_rd_chain[gi+1] = w_rd_chain[gi] | (w_sel ? w_rd : 32'h0000_0000);
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Read data
  // -------------------------------------------------------------------------
  assign w_pre_sel = ((w_ch == 4'd0) && (w_rsel == 2'd3)) ? w_pre_rd : 32'h0000_0000;

  assign data_out = (en && !reset) ? (w_rd_chain[NCHAN] | w_pre_sel) : 32'h0000_0000;

endmodule
